// File: rtl/gbt_sc_deframer_if.sv
// ---------------------------------------------------------------------------
// gbt_sc_deframer_if
// Clock/reset bundle for the GBT rx frame clock domain.
//   clk   : GBT rx frame clock
//   reset : synchronous, active-high reset
// ---------------------------------------------------------------------------
interface gbt_sc_deframer_if;
    logic clk;
    logic reset;

    modport sink (input clk, input reset);
endinterface

// File: rtl/gbt_sc_deframer.sv
// ---------------------------------------------------------------------------
// gbt_sc_deframer
// Recovers 32-bit slow-control words from the serial SC bit carried in the
// GBT frame (sc_data_b4[0]). Frame: header 8'hA5, 32 payload bits, CRC-8
// (poly 0x07, init 0) over the payload; all fields MSB first.
// A link qualifier tracks consecutive good/bad frames and a bit timeout.
//
// Ports
//   ClkRs_ix        : clock / synchronous active-high reset bundle
//   Rx_i            : serial slow-control bit
//   RxValid_i       : qualifier for Rx_i (GBT rx_clken)
//   RxReady_i       : GBT rx_ready; low aborts everything and drops the link
//   resetflags_i    : clears ErrCount_ob16 (wins over a same-cycle error)
//   data_ob32       : last CRC-good payload
//   newdata_o       : one-cycle pulse when data_ob32 updates
//   crcerror_o      : one-cycle pulse on a CRC mismatch
//   RxLocked_o      : high while a frame is being collected (DATA/CRC/CHECK)
//   SerialLinkUp_o  : link qualified
//   ErrCount_ob16   : saturating CRC error count
// DATA_W is fixed at 32 by the frame format.
// ---------------------------------------------------------------------------
module gbt_sc_deframer #(
    parameter int DATA_W       = 32,
    parameter int LOCK_COUNT   = 4,
    parameter int UNLOCK_COUNT = 2,
    parameter int TIMEOUT_BITS = 256
) (
    gbt_sc_deframer_if.sink    ClkRs_ix,
    input  logic               Rx_i,
    input  logic               RxValid_i,
    input  logic               RxReady_i,
    input  logic               resetflags_i,
    output logic [DATA_W-1:0]  data_ob32,
    output logic               newdata_o,
    output logic               crcerror_o,
    output logic               RxLocked_o,
    output logic               SerialLinkUp_o,
    output logic [15:0]        ErrCount_ob16
);

    localparam logic [7:0] HEADER    = 8'hA5;
    localparam logic [4:0] LAST_DATA = 5'(DATA_W - 1);
    localparam logic [4:0] LAST_CRC  = 5'd7;
    localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_COUNT + 1);
    localparam int TO_W   = $clog2(TIMEOUT_BITS + 1);

    typedef enum logic [1:0] {
        S_HUNT  = 2'd0,
        S_DATA  = 2'd1,
        S_CRC   = 2'd2,
        S_CHECK = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_win;
    logic [7:0]          w_win_nxt;
    logic [4:0]          r_cnt;
    logic [DATA_W-1:0]   r_payload;
    logic [7:0]          r_crc_rx;
    logic [7:0]          r_crc_calc;
    logic [DATA_W-1:0]   r_data;
    logic                r_newdata;
    logic                r_crcerr;
    logic [15:0]         r_errcnt;
    logic [GOOD_W-1:0]   r_good;
    logic [BAD_W-1:0]    r_bad;
    logic [TO_W-1:0]     r_to;
    logic                r_up_evt;
    logic                r_drop_evt;
    logic                r_linkup;

    logic                w_adv;
    logic                w_hdr_hit;
    logic                w_check;
    logic                w_crc_ok;
    logic                w_good;
    logic                w_bad;

    // One serial step of CRC-8, poly 0x07, MSB first.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign w_adv     = RxValid_i & RxReady_i;
    assign w_win_nxt = {r_win[6:0], Rx_i};
    // Window match is tested on every hunted bit, so overlapping headers work.
    assign w_hdr_hit = w_adv && (r_state == S_HUNT) && (w_win_nxt == HEADER);
    // CHECK lasts one clock whatever RxValid_i does; rx_ready low aborts it.
    assign w_check   = (r_state == S_CHECK) && RxReady_i;
    assign w_crc_ok  = (r_crc_calc == r_crc_rx);
    assign w_good    = w_check & w_crc_ok;
    assign w_bad     = w_check & ~w_crc_ok;

    // ---- frame FSM ----
    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (!RxReady_i) begin
            w_state_nxt = S_HUNT;
        end else begin
            case (r_state)
                S_HUNT:  if (w_hdr_hit) w_state_nxt = S_DATA;
                S_DATA:  if (w_adv && r_cnt == LAST_DATA) w_state_nxt = S_CRC;
                S_CRC:   if (w_adv && r_cnt == LAST_CRC) w_state_nxt = S_CHECK;
                S_CHECK: w_state_nxt = S_HUNT;
                default: w_state_nxt = S_HUNT;
            endcase
        end
    end

    // ---- bit collection: header window, bit counter, running CRC ----
    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset) begin
            r_win      <= '0;
            r_cnt      <= '0;
            r_crc_calc <= '0;
        end else if (!RxReady_i) begin
            r_win <= '0;
        end else if (w_adv) begin
            case (r_state)
                S_HUNT: begin
                    r_win <= w_win_nxt;
                    if (w_hdr_hit) begin
                        r_cnt      <= '0;
                        r_crc_calc <= '0;
                    end
                end
                S_DATA: begin
                    r_crc_calc <= crc8_step(r_crc_calc, Rx_i);
                    r_cnt      <= (r_cnt == LAST_DATA) ? '0 : r_cnt + 5'd1;
                end
                S_CRC:   r_cnt <= r_cnt + 5'd1;
                // A bit landing in the CHECK cycle already belongs to the hunt.
                S_CHECK: r_win <= w_win_nxt;
                default: ;
            endcase
        end
    end

    // Payload and received CRC shift registers carry data only, no reset.
    always_ff @(posedge ClkRs_ix.clk) begin
        if (w_adv && r_state == S_DATA) begin
            r_payload <= {r_payload[DATA_W-2:0], Rx_i};
        end
        if (w_adv && r_state == S_CRC) begin
            r_crc_rx <= {r_crc_rx[6:0], Rx_i};
        end
    end

    // ---- check results: data, pulses, error count ----
    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset) begin
            r_data    <= '0;
            r_newdata <= 1'b0;
            r_crcerr  <= 1'b0;
            r_errcnt  <= '0;
        end else begin
            r_newdata <= w_good;
            r_crcerr  <= w_bad;
            if (w_good) begin
                r_data <= r_payload;
            end
            if (resetflags_i) begin
                r_errcnt <= '0;
            end else if (w_bad) begin
                r_errcnt <= sat_inc16(r_errcnt);
            end
        end
    end

    // ---- link qualifier ----
    // The up/drop events fire only on the cycle a counter *reaches* its
    // threshold; saturated counters do not re-trigger, so a link dropped by
    // timeout stays down until a bad frame or rx_ready loss restarts locking.
    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset || !RxReady_i) begin
            r_good     <= '0;
            r_bad      <= '0;
            r_to       <= '0;
            r_up_evt   <= 1'b0;
            r_drop_evt <= 1'b0;
            r_linkup   <= 1'b0;
        end else begin
            if (r_drop_evt) begin
                r_linkup <= 1'b0;
            end else if (r_up_evt) begin
                r_linkup <= 1'b1;
            end
            r_up_evt   <= w_good && (r_good == GOOD_W'(LOCK_COUNT - 1));
            r_drop_evt <= (w_bad && (r_bad == BAD_W'(UNLOCK_COUNT - 1)))
                       || (w_adv && !w_good && (r_to == TO_W'(TIMEOUT_BITS - 1)));
            if (w_good) begin
                r_bad <= '0;
                r_to  <= '0;
                if (r_good != GOOD_W'(LOCK_COUNT)) r_good <= r_good + 1'b1;
            end else begin
                if (w_bad) begin
                    r_good <= '0;
                    if (r_bad != BAD_W'(UNLOCK_COUNT)) r_bad <= r_bad + 1'b1;
                end
                if (w_adv && r_to != TO_W'(TIMEOUT_BITS)) r_to <= r_to + 1'b1;
            end
        end
    end

    assign data_ob32      = r_data;
    assign newdata_o      = r_newdata;
    assign crcerror_o     = r_crcerr;
    assign ErrCount_ob16  = r_errcnt;
    assign SerialLinkUp_o = r_linkup;
    assign RxLocked_o     = (r_state != S_HUNT);

endmodule

// File: tb/tb_gbt_sc_deframer.sv
// ---------------------------------------------------------------------------
// tb_gbt_sc_deframer
// Scoreboarded bench: each driven cycle runs a frame-level reference model
// that pushes the expected post-edge outputs into a queue; a monitor pops
// and compares one entry per clock, #1 after the rising edge.
// ---------------------------------------------------------------------------
module tb_gbt_sc_deframer;

    localparam int LOCK   = 4;
    localparam int UNLOCK = 2;
    localparam int TO     = 256;

    gbt_sc_deframer_if u_clkrs ();

    logic        rx, rxvalid, rxready, rflags;
    logic [31:0] data;
    logic        newdata, crcerr, locked, linkup;
    logic [15:0] errcnt;

    gbt_sc_deframer #(
        .DATA_W       (32),
        .LOCK_COUNT   (LOCK),
        .UNLOCK_COUNT (UNLOCK),
        .TIMEOUT_BITS (TO)
    ) dut (
        .ClkRs_ix       (u_clkrs),
        .Rx_i           (rx),
        .RxValid_i      (rxvalid),
        .RxReady_i      (rxready),
        .resetflags_i   (rflags),
        .data_ob32      (data),
        .newdata_o      (newdata),
        .crcerror_o     (crcerr),
        .RxLocked_o     (locked),
        .SerialLinkUp_o (linkup),
        .ErrCount_ob16  (errcnt)
    );

    initial u_clkrs.clk = 1'b0;
    always #5 u_clkrs.clk = ~u_clkrs.clk;

    typedef struct {
        logic        link;
        logic        newdata;
        logic        crcerr;
        logic        locked;
        logic [31:0] data;
        logic [15:0] err;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_newdata = 0;
    int n_crcerr  = 0;

    // Reference model state (after the most recently modelled edge).
    bit          m_collect, m_check, m_up, m_drop, m_link;
    int          m_nbits, m_good, m_bad, m_to, m_err;
    logic [39:0] m_frame;
    logic [7:0]  m_win;
    logic [31:0] m_data;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, want, $time);
        end
    endfunction

    function automatic logic [7:0] crc8_ref(input logic [31:0] p);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ p[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic void push_exp(input bit nd, input bit ce);
        exp_t e;
        e.link    = m_link;
        e.newdata = nd;
        e.crcerr  = ce;
        e.locked  = m_collect | m_check;
        e.data    = m_data;
        e.err     = m_err[15:0];
        exp_q.push_back(e);
    endfunction

    function automatic void model_reset();
        m_collect = 0; m_check = 0; m_up = 0; m_drop = 0; m_link = 0;
        m_nbits = 0; m_good = 0; m_bad = 0; m_to = 0; m_err = 0;
        m_win = 8'h00; m_data = 32'h0; m_frame = 40'h0;
        push_exp(0, 0);
    endfunction

    // One clock of the link as the rules describe it: hunt for A5, take 40
    // more valid bits, judge the frame on the following clock.
    function automatic void model_step(input logic v, input logic b, input logic rdy, input logic rf);
        bit a, good_f, bad_f;
        logic [31:0] pl;
        a = v & rdy; good_f = 0; bad_f = 0;
        if (!rdy) begin
            m_collect = 0; m_check = 0; m_nbits = 0; m_win = 8'h00;
            m_good = 0; m_bad = 0; m_to = 0; m_up = 0; m_drop = 0; m_link = 0;
        end else begin
            if (m_drop) m_link = 0;
            else if (m_up) m_link = 1;
            m_up = 0; m_drop = 0;
            if (m_check) begin
                pl = m_frame[39:8];
                if (crc8_ref(pl) == m_frame[7:0]) begin
                    good_f = 1; m_data = pl;
                end else begin
                    bad_f = 1;
                end
                if (a) m_win = {m_win[6:0], b};
                m_check = 0;
            end else if (m_collect) begin
                if (a) begin
                    m_frame = {m_frame[38:0], b};
                    m_nbits++;
                    if (m_nbits == 40) begin m_collect = 0; m_check = 1; end
                end
            end else if (a) begin
                m_win = {m_win[6:0], b};
                if (m_win == 8'hA5) begin m_collect = 1; m_nbits = 0; end
            end
            if (good_f) begin
                m_bad = 0; m_to = 0;
                if (m_good < LOCK) begin m_good++; if (m_good == LOCK) m_up = 1; end
            end else begin
                if (bad_f) begin
                    m_good = 0;
                    if (m_bad < UNLOCK) begin m_bad++; if (m_bad == UNLOCK) m_drop = 1; end
                end
                if (a && m_to < TO) begin m_to++; if (m_to == TO) m_drop = 1; end
            end
        end
        if (rf) m_err = 0;
        else if (bad_f && m_err < 65535) m_err++;
        push_exp(good_f, bad_f);
    endfunction

    task automatic cyc(input logic v, input logic b, input logic rdy, input logic rf);
        @(negedge u_clkrs.clk);
        u_clkrs.reset = 1'b0;
        rxvalid = v; rx = b; rxready = rdy; rflags = rf;
        model_step(v, b, rdy, rf);
    endtask

    task automatic rst_cyc();
        @(negedge u_clkrs.clk);
        u_clkrs.reset = 1'b1;
        rxvalid = 1'b0; rx = 1'b0; rxready = 1'b1; rflags = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Sends the top nb bits of fr, with gap invalid cycles before each bit.
    task automatic send_bits(input logic [47:0] fr, input int nb, input int gap);
        for (int i = 47; i >= 48 - nb; i--) begin
            repeat (gap) cyc(1'b0, 1'b0, 1'b1, 1'b0);
            cyc(1'b1, fr[i], 1'b1, 1'b0);
        end
    endtask

    task automatic send_frame(input logic [31:0] p, input logic [7:0] c, input int gap);
        send_bits({8'hA5, p, c}, 48, gap);
    endtask

    task automatic rnd_bit(input logic b);
        repeat ($urandom_range(0, 2))
            cyc(1'b0, 1'b0, ($urandom_range(0, 399) != 0), ($urandom_range(0, 99) < 2));
        cyc(1'b1, b, ($urandom_range(0, 399) != 0), ($urandom_range(0, 99) < 2));
    endtask

    // Monitor: one expected entry per clock edge.
    always @(posedge u_clkrs.clk) begin : mon
        exp_t e;
        #1;
        if (newdata === 1'b1) n_newdata++;
        if (crcerr === 1'b1) n_crcerr++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("mon_linkup",  32'(linkup),  32'(e.link));
            chk("mon_newdata", 32'(newdata), 32'(e.newdata));
            chk("mon_crcerr",  32'(crcerr),  32'(e.crcerr));
            chk("mon_locked",  32'(locked),  32'(e.locked));
            chk("mon_data",    data,         e.data);
            chk("mon_errcnt",  32'(errcnt),  32'(e.err));
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int nd, ce;
        logic [31:0] p;
        logic [7:0]  c;
        u_clkrs.reset = 1'b1;
        rx = 1'b0; rxvalid = 1'b0; rxready = 1'b1; rflags = 1'b0;

        repeat (3) rst_cyc();
        idle(1);
        chk("rst_data",    data, 32'h0);
        chk("rst_errcnt",  32'(errcnt), 32'h0);
        chk("rst_newdata", 32'(newdata), 32'h0);
        chk("rst_crcerr",  32'(crcerr), 32'h0);
        chk("rst_locked",  32'(locked), 32'h0);
        chk("rst_linkup",  32'(linkup), 32'h0);

        // Single frame, RxValid every third cycle.
        nd = n_newdata;
        send_frame(32'h0000_0001, 8'h07, 2);
        idle(3);
        chk("f1_newdata_cnt", 32'(n_newdata - nd), 32'd1);
        chk("f1_data", data, 32'h0000_0001);
        chk("f1_errcnt", 32'(errcnt), 32'h0);

        // Fresh lock: four back-to-back all-zero frames.
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send_frame(32'h0, 8'h00, 0);
        idle(2);
        chk("lock_newdata", 32'(newdata), 32'd1);
        chk("lock_link_before", 32'(linkup), 32'd0);
        idle(1);
        chk("lock_link_after", 32'(linkup), 32'd1);

        // Two CRC errors with link up.
        send_frame(32'h1234_5678, crc8_ref(32'h1234_5678), 0);
        ce = n_crcerr;
        for (int k = 0; k < 2; k++) send_frame(32'hDEAD_BEEF, crc8_ref(32'hDEAD_BEEF) ^ 8'h01, 0);
        idle(4);
        chk("bad_crcerr_cnt", 32'(n_crcerr - ce), 32'd2);
        chk("bad_errcnt", 32'(errcnt), 32'd2);
        chk("bad_link", 32'(linkup), 32'd0);
        chk("bad_data_hold", data, 32'h1234_5678);

        // Clear in the same cycle as an error at count 5.
        for (int k = 0; k < 3; k++) send_frame(32'h0F0F_0F0F, 8'h5A, 0);
        idle(2);
        chk("err5", 32'(errcnt), 32'd5);
        ce = n_crcerr;
        send_frame(32'hFFFF_0000, 8'h00, 0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);
        chk("clr_errcnt", 32'(errcnt), 32'd0);
        chk("clr_crcerr_cnt", 32'(n_crcerr - ce), 32'd1);

        // Bit timeout with link up.
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send_frame(32'hA0B1_C2D3, crc8_ref(32'hA0B1_C2D3), 0);
        idle(3);
        chk("to_link_up", 32'(linkup), 32'd1);
        repeat (255) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("to_255_link", 32'(linkup), 32'd1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);
        chk("to_256_link", 32'(linkup), 32'd0);
        nd = n_newdata;
        send_frame(32'h55AA_33CC, crc8_ref(32'h55AA_33CC), 0);
        idle(4);
        chk("to_good_newdata", 32'(n_newdata - nd), 32'd1);
        chk("to_good_data", data, 32'h55AA_33CC);
        chk("to_good_link", 32'(linkup), 32'd0);

        // rx_ready glitch at payload bit 20.
        nd = n_newdata; ce = n_crcerr;
        send_bits({8'hA5, 32'h0, 8'h00}, 28, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);
        chk("rdy_no_newdata", 32'(n_newdata - nd), 32'd0);
        chk("rdy_no_crcerr", 32'(n_crcerr - ce), 32'd0);
        chk("rdy_locked", 32'(locked), 32'd0);
        send_frame(32'hCAFE_F00D, crc8_ref(32'hCAFE_F00D), 1);
        idle(3);
        chk("rdy_next_newdata", 32'(n_newdata - nd), 32'd1);
        chk("rdy_next_data", data, 32'hCAFE_F00D);

        // Reset in the middle of a frame.
        nd = n_newdata; ce = n_crcerr;
        send_bits({8'hA5, 32'h1357_9BDF, 8'h00}, 18, 0);
        rst_cyc();
        idle(3);
        chk("mrst_no_pulse", 32'((n_newdata - nd) + (n_crcerr - ce)), 32'd0);
        chk("mrst_data", data, 32'h0);
        chk("mrst_locked", 32'(locked), 32'd0);
        send_frame(32'h2468_ACE0, crc8_ref(32'h2468_ACE0), 0);
        idle(3);
        chk("mrst_next_data", data, 32'h2468_ACE0);

        // Randomized traffic against the model.
        for (int f = 0; f < 80; f++) begin
            p = $urandom;
            c = crc8_ref(p);
            if ($urandom_range(0, 3) == 0) c = c ^ (8'd1 << $urandom_range(0, 7));
            repeat ($urandom_range(0, 4)) rnd_bit(1'($urandom_range(0, 1)));
            for (int i = 47; i >= 0; i--) begin
                logic [47:0] fr;
                fr = {8'hA5, p, c};
                rnd_bit(fr[i]);
            end
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gbt_sc_deframer.md
GBT_SC_DEFRAMER -- requirements
Module: gbt_sc_deframer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width; only 32 is supported.
REQ-002 SHALL have parameter LOCK_COUNT, default 4, consecutive good frames needed to declare link up.
REQ-003 SHALL have parameter UNLOCK_COUNT, default 2, consecutive bad frames that drop the link.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 256, valid bits without a good frame that drop the link.
REQ-005 SHALL have port ClkRs_ix.clk, input, 1 bit: the single clock (GBT rx frame clock domain).
REQ-006 SHALL have port ClkRs_ix.reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port Rx_i, input, 1 bit: serial slow-control bit, taken from received frame sc_data_b4[0].
REQ-008 SHALL have port RxValid_i, input, 1 bit: qualifier for Rx_i (GBT rx_clken).
REQ-009 SHALL have port RxReady_i, input, 1 bit: GBT rx_ready; low means the link is not usable.
REQ-010 SHALL have port resetflags_i, input, 1 bit: clears ErrCount_ob16.
REQ-011 SHALL have port data_ob32, output, 32 bits: last CRC-good payload.
REQ-012 SHALL have port newdata_o, output, 1 bit: one-cycle pulse when data_ob32 updates.
REQ-013 SHALL have port crcerror_o, output, 1 bit: one-cycle pulse on a CRC mismatch.
REQ-014 SHALL have port RxLocked_o, output, 1 bit: high while a frame is being collected (after header match).
REQ-015 SHALL have port SerialLinkUp_o, output, 1 bit: link qualified.
REQ-016 SHALL have port ErrCount_ob16, output, 16 bits: saturating count of CRC errors.

Function
REQ-017 SHALL process Rx_i only in cycles where RxValid_i=1 and RxReady_i=1; all other cycles hold state, except as REQ-026 and REQ-027 state.
REQ-018 SHALL use frame format: 8-bit header 8'hA5, then 32 payload bits, then 8 CRC bits; all fields MSB first; 48 bits total.
REQ-019 SHALL implement FSM states HUNT, DATA, CRC and CHECK; the reset state SHALL be HUNT.
REQ-020 SHALL, in HUNT, shift each valid bit into an 8-bit window and go to DATA in the cycle the window equals 8'hA5; overlapping matches SHALL be allowed.
REQ-021 SHALL, in DATA, collect 32 valid bits and then go to CRC; in CRC, collect 8 valid bits and then go to CHECK.
REQ-022 SHALL, in CHECK, take exactly one clock regardless of RxValid_i and then return to HUNT; a bit arriving during the CHECK cycle SHALL be shifted into the HUNT window.
REQ-023 SHALL compute CRC-8 serially over the payload bits only: polynomial 0x07, init 0x00, not reflected, no final XOR; per bit fb=crc[7]^bit, then crc={crc[6:0],1'b0}^(fb?8'h07:8'h00).
REQ-024 SHALL, in CHECK when the CRC matches: load data_ob32 and pulse newdata_o, both registered in that cycle and visible on the next edge.
REQ-025 SHALL, in CHECK when the CRC mismatches: hold data_ob32, pulse crcerror_o, and increment ErrCount_ob16, saturating at 16'hFFFF.
REQ-026 SHALL, when resetflags_i=1, set ErrCount_ob16 to 0; clearing has priority over a same-cycle increment, so that error is not counted.
REQ-027 SHALL, when RxReady_i=0: force HUNT, clear the window, good/bad/timeout counters and SerialLinkUp_o; abort any partial frame with no pulses; hold data_ob32 and ErrCount_ob16.
REQ-028 SHALL keep saturating good/bad counters: a good frame sets bad to 0 and increments good; a bad frame sets good to 0 and increments bad.
REQ-029 SHALL set SerialLinkUp_o in the cycle after good reaches LOCK_COUNT; it SHALL clear in the cycle after bad reaches UNLOCK_COUNT or the timeout reaches TIMEOUT_BITS.
REQ-030 SHALL have the timeout count valid bits, clear on every good frame, and saturate at TIMEOUT_BITS.
REQ-031 SHALL drive RxLocked_o high exactly in states DATA, CRC and CHECK.

Reset
REQ-032 SHALL, on ClkRs_ix.reset=1 at a clock edge, set: state HUNT, window 0, all counters 0, data_ob32=0, ErrCount_ob16=0, and newdata_o, crcerror_o, RxLocked_o, SerialLinkUp_o all 0.
REQ-033 SHALL abort a frame in progress when reset is asserted mid-frame, with no newdata_o or crcerror_o pulse.

Verification
REQ-034 Single frame A5, 0x00000001, 0x07 with RxValid_i every third cycle -> one newdata_o pulse, data_ob32=0x00000001, ErrCount_ob16=0.
REQ-035 Four back-to-back good frames with payload 0x00000000 and CRC 0x00 -> SerialLinkUp_o rises one cycle after the 4th CHECK.
REQ-036 With link up, two frames with a flipped CRC bit -> two crcerror_o pulses, ErrCount_ob16=2, SerialLinkUp_o falls, data_ob32 unchanged.
REQ-037 With link up, 256 valid idle 0 bits -> SerialLinkUp_o falls; the next good frame -> newdata_o pulses, link still down.
REQ-038 RxReady_i low for 1 cycle during bit 20 of the payload -> no pulse; a subsequent good frame is received correctly.
REQ-039 resetflags_i asserted in the same cycle as a CRC error with ErrCount_ob16=5 -> ErrCount_ob16=0.
